instr_decode_stage: RTL and testbench
=====================================

// Module: instr_decode_stage
// PURPOSE
//  Registered, parametrised decode stage between fetch and execute. Classifies each 32-bit
//  instruction into one-hot R/I/S/B/U/J type, extracts rd/rs1/rs2/funct3/funct7 and a
//  sign-extended immediate. Valid/ready on both sides, 2-entry skid buffer, flush input.
// PARAMETERS
//  XLEN      32   immediate and PC width; legal values 32 or 64
//  CNT_W     16   width of the illegal-instruction counter (DECODE_ILLEGAL_EN only)
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst          in   1     synchronous active-high reset
//  flush        in   1     discard all buffered instructions
//  in_valid     in   1     upstream instruction valid
//  in_ready     out  1     stage can accept an instruction
//  in_instr     in   32    instruction word
//  in_pc        in   XLEN  instruction PC
//  out_valid    out  1     decoded bundle valid
//  out_ready    in   1     downstream accepts bundle
//  out_pc       out  XLEN  PC of decoded instruction
//  out_type     out  6     one-hot {j,u,b,s,i,r}; 0 = unrecognised opcode
//  out_rd/rs1/rs2 out 5    register indices instr[11:7]/[19:15]/[24:20]
//  out_funct3   out  3     instr[14:12]
//  out_funct7   out  7     instr[31:25]
//  out_imm      out  XLEN  sign-extended immediate
//  out_illegal  out  1     (DECODE_ILLEGAL_EN) unrecognised opcode flag
//  illegal_cnt  out  CNT_W (DECODE_ILLEGAL_EN) saturating count of accepted illegal instrs
// BEHAVIOUR
//  - Opcode map: R=0110011; I=0010011,0000011,1100111; S=0100011; B=1100011;
//    U=0110111,0010111; J=1101111. Anything else -> out_type=0.
//  - Immediates (bit 31 replicated to XLEN): I {[31:20]}; S {[31:25],[11:7]};
//    B {[31],[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0};
//    R and unrecognised -> 0.
//  - Decode is combinational on in_instr; result captured in output register on input
//    handshake (in_valid & in_ready). Latency 1 cycle: accepted at edge N, out_valid at N+1.
//  - Skid: output reg + one skid reg. in_ready = !skid_full (registered, no comb path from
//    out_ready). Output held while out_valid & !out_ready -> new accept goes to skid; on
//    next output handshake skid moves to output reg. Order strictly preserved.
//  - Output fields stable while out_valid & !out_ready. Simultaneous in/out handshake with
//    empty skid: output reg loads new instr, out_valid stays 1, zero bubbles.
//  - Throughput 1/cycle when out_ready held high.
//  - flush: at next edge clear output and skid valids; in_valid that cycle is dropped;
//    in_ready=1 following cycle. flush overrides simultaneous handshakes.
//  - Reset: out_valid=0, skid empty, in_ready=1, all data outputs 0, illegal_cnt=0.
//    Reset mid-transfer drops buffered instructions; no partial bundle ever emitted.
// CONFIGURATION
//  DECODE_ILLEGAL_EN defined: out_illegal=1 with bundle when out_type==0; illegal_cnt
//  increments on each accepted illegal instr, saturates at 2^CNT_W-1, cleared only by rst
//  (not flush). Undefined: ports out_illegal and illegal_cnt absent; unrecognised opcodes
//  pass with out_type=0, out_imm=0.
// TESTING
//  1 addi x5,x1,-1 (0xFFF08293), out_ready=1 -> next cycle type=000010, rd=5, rs1=1,
//    imm=0xFFFF_FFFF (XLEN=32).
//  2 beq stream 0xFE000EE3, jal 0x0080006F -> B imm=-4, J imm=8; back-to-back, no bubble.
//  3 out_ready=0 for 3 cycles while 3 instrs offered -> 2 accepted, in_ready=0, third
//    stalled; release -> all three emerge in order, held fields stable during stall.
//  4 flush with full skid and in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing
//    emitted for flushed/dropped instrs.
//  5 DECODE_ILLEGAL_EN, CNT_W=2: send 0x00000000 five times -> out_illegal=1 each,
//    illegal_cnt 1,2,3,3,3; rst -> 0. Without macro: type=0, imm=0, no counter.
//  6 rst asserted while out_valid & !out_ready -> following cycle out_valid=0, outputs 0.

Source files
------------

// File: rtl/instr_decode_stage_if.sv
// Fetch-to-execute decode bus: instruction side (in_*) and decoded-bundle side (out_*).
// The stage uses the slave modport; the environment driving it uses master.
interface instr_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [5:0]      out_type;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_type, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_type, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm
    );
endinterface

// File: rtl/instr_decode_stage.sv
// Registered decode stage with a 2-entry (output + skid) buffer and flush.
// Optional macro DECODE_ILLEGAL_EN adds out_illegal and a saturating illegal_cnt.
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    instr_decode_stage_if.slave   bus
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic                  out_illegal,
    output logic [CNT_W-1:0]      illegal_cnt
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [5:0] TYPE_R = 6'b000001;
    localparam logic [5:0] TYPE_I = 6'b000010;
    localparam logic [5:0] TYPE_S = 6'b000100;
    localparam logic [5:0] TYPE_B = 6'b001000;
    localparam logic [5:0] TYPE_U = 6'b010000;
    localparam logic [5:0] TYPE_J = 6'b100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [5:0]      typ;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
    } bundle_t;

    bundle_t     dec;
    logic [31:0] imm32;
    logic [31:0] instr;

    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_ready;
    logic    in_hs;

    assign instr = bus.in_instr;

    always_comb begin
        imm32      = 32'd0;
        dec        = '0;
        dec.pc     = bus.in_pc;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        dec.funct7 = instr[31:25];
        case (instr[6:0])
            OP_R: dec.typ = TYPE_R;
            OP_IMM, OP_LOAD, OP_JALR: begin
                dec.typ = TYPE_I;
                imm32   = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                dec.typ = TYPE_S;
                imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                dec.typ = TYPE_B;
                imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.typ = TYPE_U;
                imm32   = {instr[31:12], 12'd0};
            end
            OP_JAL: begin
                dec.typ = TYPE_J;
                imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
            end
            default: dec.typ = 6'd0;
        endcase
        dec.imm = XLEN'($signed(imm32));
    end

    // in_ready depends only on registered state, so out_ready never reaches it combinationally.
    assign in_ready = !skid_valid_q;
    assign in_hs    = bus.in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
            // Output register is free this cycle; the older skid entry always goes first.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_hs) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_hs) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_pc     = out_q.pc;
    assign bus.out_type   = out_q.typ;
    assign bus.out_rd     = out_q.rd;
    assign bus.out_rs1    = out_q.rs1;
    assign bus.out_rs2    = out_q.rs2;
    assign bus.out_funct3 = out_q.funct3;
    assign bus.out_funct7 = out_q.funct7;
    assign bus.out_imm    = out_q.imm;

`ifdef DECODE_ILLEGAL_EN
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    // Survives flush on purpose: only reset clears the count.
    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (!flush && in_hs && (dec.typ == 6'd0) && (illegal_cnt_q != {CNT_W{1'b1}}))
            illegal_cnt_d = illegal_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) illegal_cnt_q <= '0;
        else     illegal_cnt_q <= illegal_cnt_d;
    end

    assign out_illegal = out_valid_q && (out_q.typ == 6'd0);
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Randomised and directed bench for instr_decode_stage against a queue-based reference.
module tb_instr_decode_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    instr_decode_stage_if #(.XLEN(XLEN)) bus ();

`ifdef DECODE_ILLEGAL_EN
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;
`endif

    instr_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus)
`ifdef DECODE_ILLEGAL_EN
        ,
        .out_illegal (out_illegal),
        .illegal_cnt (illegal_cnt)
`endif
    );

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [5:0]      typ;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cnt_model = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Decode from the instruction-set rules using plain integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [XLEN-1:0] pc);
        exp_t   e;
        longint u;
        longint v;
        int     op;
        int     k;
        u = longint'({32'd0, w});
        op = int'(u % 128);
        v = 0;
        k = -1;
        e.pc     = pc;
        e.rd     = 5'((u >> 7) % 32);
        e.rs1    = 5'((u >> 15) % 32);
        e.rs2    = 5'((u >> 20) % 32);
        e.funct3 = 3'((u >> 12) % 8);
        e.funct7 = 7'((u >> 25) % 128);
        case (op)
            'h33: k = 0;
            'h13, 'h03, 'h67: begin
                k = 1;
                v = u >> 20;
                if (v >= 2048) v -= 4096;
            end
            'h23: begin
                k = 2;
                v = ((u >> 25) << 5) + ((u >> 7) % 32);
                if (v >= 2048) v -= 4096;
            end
            'h63: begin
                k = 3;
                v = (((u >> 31) % 2) << 12) + (((u >> 7) % 2) << 11)
                  + (((u >> 25) % 64) << 5) + (((u >> 8) % 16) << 1);
                if (v >= 4096) v -= 8192;
            end
            'h37, 'h17: begin
                k = 4;
                v = (u >> 12) << 12;
                if (v >= 64'sd2147483648) v -= 64'sd4294967296;
            end
            'h6f: begin
                k = 5;
                v = (((u >> 31) % 2) << 20) + (((u >> 12) % 256) << 12)
                  + (((u >> 20) % 2) << 11) + (((u >> 21) % 1024) << 1);
                if (v >= 1048576) v -= 2097152;
            end
            default: k = -1;
        endcase
        e.typ = 6'd0;
        if (k >= 0) e.typ[k] = 1'b1;
        e.imm = v[XLEN-1:0];
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] w, input logic [XLEN-1:0] pc,
                         input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_instr  = w;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    // One cycle: check at negedge, advance the model at posedge, return at posedge+1.
    task automatic step();
        logic in_hs;
        logic out_hs;
        exp_t h;
        exp_t e;
        @(negedge clk);
        check_eq("out_valid", 64'(bus.out_valid), 64'(sb.size() > 0));
        check_eq("in_ready", 64'(bus.in_ready), 64'(sb.size() < 2));
        if (sb.size() > 0) begin
            h = sb[0];
            check_eq("out_pc", 64'(bus.out_pc), 64'(h.pc));
            check_eq("out_type", 64'(bus.out_type), 64'(h.typ));
            check_eq("out_regs", 64'({bus.out_rd, bus.out_rs1, bus.out_rs2}),
                     64'({h.rd, h.rs1, h.rs2}));
            check_eq("out_funct", 64'({bus.out_funct7, bus.out_funct3}),
                     64'({h.funct7, h.funct3}));
            check_eq("out_imm", 64'(bus.out_imm), 64'(h.imm));
`ifdef DECODE_ILLEGAL_EN
            check_eq("out_illegal", 64'(out_illegal), 64'(h.typ == 6'd0));
`endif
        end
`ifdef DECODE_ILLEGAL_EN
        check_eq("illegal_cnt", 64'(illegal_cnt), 64'(cnt_model));
`endif
        in_hs  = bus.in_valid && (sb.size() < 2);
        out_hs = (sb.size() > 0) && bus.out_ready;
        e = ref_decode(bus.in_instr, bus.in_pc);
        @(posedge clk);
        if (rst) begin
            sb.delete();
            cnt_model = 0;
        end else if (flush) begin
            sb.delete();
        end else begin
            if (out_hs) void'(sb.pop_front());
            if (in_hs) begin
                sb.push_back(e);
                if (e.typ == 6'd0 && cnt_model < (1 << CNT_W) - 1) cnt_model++;
            end
        end
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        check_eq({tag, "_data"}, 64'({bus.out_type, bus.out_rd, bus.out_rs1, bus.out_rs2,
                                      bus.out_funct3, bus.out_funct7}), 64'd0);
        check_eq({tag, "_pc"}, 64'(bus.out_pc), 64'd0);
        check_eq({tag, "_imm"}, 64'(bus.out_imm), 64'd0);
`ifdef DECODE_ILLEGAL_EN
        check_eq({tag, "_cnt"}, 64'(illegal_cnt), 64'd0);
`endif
    endtask

    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        drive(1'b0, 32'd0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");

        // addi x5,x1,-1
        drive(1'b1, 32'hFFF08293, 32'h100, 1'b1, 1'b0);
        step();
        $display("t1 addi: type=%b rd=%0d rs1=%0d imm=%h", bus.out_type, bus.out_rd,
                 bus.out_rs1, bus.out_imm);
        check_eq("t1_type", 64'(bus.out_type), 64'b000010);
        check_eq("t1_rd_rs1", 64'({bus.out_rd, bus.out_rs1}), 64'({5'd5, 5'd1}));
        check_eq("t1_imm", 64'(bus.out_imm), 64'hFFFF_FFFF);
        drive(1'b0, 32'd0, '0, 1'b1, 1'b0);
        step();

        // beq then jal, back to back
        drive(1'b1, 32'hFE000EE3, 32'h200, 1'b1, 1'b0);
        step();
        check_eq("t2_b_type", 64'(bus.out_type), 64'b001000);
        check_eq("t2_b_imm", 64'(bus.out_imm), 64'hFFFF_FFFC);
        drive(1'b1, 32'h0080006F, 32'h204, 1'b1, 1'b0);
        step();
        $display("t2 jal: valid=%b type=%b imm=%h", bus.out_valid, bus.out_type, bus.out_imm);
        check_eq("t2_j_valid", 64'(bus.out_valid), 64'd1);
        check_eq("t2_j_type", 64'(bus.out_type), 64'b100000);
        check_eq("t2_j_imm", 64'(bus.out_imm), 64'd8);
        drive(1'b0, 32'd0, '0, 1'b1, 1'b0);
        step();

        // stall: three offered, two accepted
        drive(1'b1, 32'h00A00093, 32'h300, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00B00113, 32'h304, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00C00193, 32'h308, 1'b0, 1'b0);
        step();
        check_eq("t3_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("t3_held_pc", 64'(bus.out_pc), 64'h300);
        drive(1'b1, 32'h00C00193, 32'h308, 1'b1, 1'b0);
        repeat (2) step();
        drive(1'b0, 32'd0, '0, 1'b1, 1'b0);
        repeat (2) step();

        // flush with full skid and a concurrent offer
        drive(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00200093, 32'h404, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00300093, 32'h408, 1'b0, 1'b1);
        step();
        $display("t4 flush: valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
        check_eq("t4_valid", 64'(bus.out_valid), 64'd0);
        check_eq("t4_ready", 64'(bus.in_ready), 64'd1);
        drive(1'b0, 32'd0, '0, 1'b1, 1'b0);
        repeat (2) step();

        // all-zero word is unrecognised
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'd0, XLEN'(32'h500 + 4 * i), 1'b1, 1'b0);
            step();
            check_eq("t5_type", 64'(bus.out_type), 64'd0);
            check_eq("t5_imm", 64'(bus.out_imm), 64'd0);
`ifdef DECODE_ILLEGAL_EN
            check_eq("t5_illegal", 64'(out_illegal), 64'd1);
            check_eq("t5_cnt", 64'(illegal_cnt), 64'(i < 3 ? i + 1 : 3));
`endif
        end
        drive(1'b0, 32'd0, '0, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("t5_rst");

        // reset while output is stalled
        drive(1'b1, 32'h12345037, 32'h600, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00400093, 32'h604, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("t6_rst");
        drive(1'b0, 32'd0, '0, 1'b1, 1'b0);
        repeat (2) step();

        // random traffic
        for (int c = 0; c < 600; c++) begin
            w = $urandom;
            if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 8)];
            drive($urandom_range(0, 9) < 7, w, XLEN'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
            rst = ($urandom_range(0, 199) == 0);
            step();
            rst = 1'b0;
        end
        drive(1'b0, 32'd0, '0, 1'b1, 1'b0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
